// File: rtl/sprite_hit_pipeline.sv
// Purpose: per-pixel sprite hit test against frame-latched sprite positions; reports winning sprite + offsets.
// Latency: 2 cycles from pix_* to out_*, one pixel per cycle, fully pipelined.
// Backpressure: none; the pipeline never stalls, and pix_valid==0 cycles shift through as bubbles.
//
// Ports:
//   clock, reset           posedge clock, synchronous active-low reset
//   sprite_x / sprite_y    32 bits per sprite, sprite i at [32*i +: 32] (live regfile taps)
//   screen_end             nonzero = game over, latched at frame_start
//   frame_start            one-cycle pulse; snapshots sprite positions and game-over flag
//   pix_valid/pix_x/pix_y  pixel under test
//   out_*                  stage-2 results; out_game_over is the latched game-over flag
module sprite_hit_pipeline #(
  parameter int N_SPRITES = 8,
  parameter int COORD_W   = 10,
  parameter int SPRITE_W  = 32,
  parameter int SPRITE_H  = 32,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [32*N_SPRITES-1:0]       sprite_x,
  input  logic [32*N_SPRITES-1:0]       sprite_y,
  input  logic [31:0]                   screen_end,
  input  logic                          frame_start,
  input  logic                          pix_valid,
  input  logic [COORD_W-1:0]            pix_x,
  input  logic [COORD_W-1:0]            pix_y,
  output logic                          out_valid,
  output logic                          out_hit,
  output logic [2:0]                    out_idx,
  output logic [$clog2(SPRITE_W)-1:0]   out_offs_x,
  output logic [$clog2(SPRITE_H)-1:0]   out_offs_y,
  output logic                          out_game_over
);

  localparam int OXW = $clog2(SPRITE_W);
  localparam int OYW = $clog2(SPRITE_H);

  // Limits widened by one bit so sprite end positions never wrap.
  localparam logic [COORD_W:0] H_LIM  = (COORD_W+1)'(H_ACTIVE);
  localparam logic [COORD_W:0] V_LIM  = (COORD_W+1)'(V_ACTIVE);
  localparam logic [COORD_W:0] W_EXT  = (COORD_W+1)'(SPRITE_W);
  localparam logic [COORD_W:0] H_EXT  = (COORD_W+1)'(SPRITE_H);

  // Positions that do not fit in COORD_W bits collapse to all-ones, which is
  // always past the visible area and therefore disables the sprite.
  function automatic logic [COORD_W-1:0] sat(input logic [31:0] v);
    return (|v[31:COORD_W]) ? '1 : v[COORD_W-1:0];
  endfunction

  // Frame-latched sprite positions (tear-free snapshot).
  logic [COORD_W-1:0] sh_x [N_SPRITES];
  logic [COORD_W-1:0] sh_y [N_SPRITES];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        sh_x[i] <= '1;
        sh_y[i] <= '1;
      end
      out_game_over <= 1'b0;
    end else if (frame_start) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        sh_x[i] <= sat(sprite_x[32*i +: 32]);
        sh_y[i] <= sat(sprite_y[32*i +: 32]);
      end
      out_game_over <= |screen_end;
    end
  end

  // Per-sprite hit test and offsets (combinational, against current shadows).
  logic [N_SPRITES-1:0] hit_c;
  logic [OXW-1:0]       offx_c [N_SPRITES];
  logic [OYW-1:0]       offy_c [N_SPRITES];

  genvar g;
  generate
    for (g = 0; g < N_SPRITES; g++) begin : g_spr
      logic [COORD_W:0]   sx, sy, px, py, x_end, y_end;
      logic [COORD_W-1:0] dx, dy;
      logic               en;

      assign sx    = {1'b0, sh_x[g]};
      assign sy    = {1'b0, sh_y[g]};
      assign px    = {1'b0, pix_x};
      assign py    = {1'b0, pix_y};
      assign x_end = sx + W_EXT;
      assign y_end = sy + H_EXT;
      assign en    = (sx < H_LIM) && (sy < V_LIM);
      assign hit_c[g] = en && (px >= sx) && (px < x_end) && (py >= sy) && (py < y_end);

      // Only meaningful when hit; low bits of the difference are the in-sprite offset.
      assign dx = pix_x - sh_x[g];
      assign dy = pix_y - sh_y[g];
      assign offx_c[g] = dx[OXW-1:0];
      assign offy_c[g] = dy[OYW-1:0];
    end
  endgenerate

  // Stage 1 registers.
  logic [N_SPRITES-1:0] s1_hit;
  logic [OXW-1:0]       s1_offx [N_SPRITES];
  logic [OYW-1:0]       s1_offy [N_SPRITES];
  logic                 s1_vld;

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_vld <= 1'b0;
      s1_hit <= '0;
      for (int i = 0; i < N_SPRITES; i++) begin
        s1_offx[i] <= '0;
        s1_offy[i] <= '0;
      end
    end else begin
      s1_vld <= pix_valid;
      s1_hit <= hit_c;
      for (int i = 0; i < N_SPRITES; i++) begin
        s1_offx[i] <= offx_c[i];
        s1_offy[i] <= offy_c[i];
      end
    end
  end

  // Stage 2 priority encode: scan high to low so the lowest index wins.
  logic           win_hit;
  logic [2:0]     win_idx;
  logic [OXW-1:0] win_ox;
  logic [OYW-1:0] win_oy;

  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    win_ox  = '0;
    win_oy  = '0;
    for (int i = N_SPRITES-1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        win_hit = 1'b1;
        win_idx = 3'(i);
        win_ox  = s1_offx[i];
        win_oy  = s1_offy[i];
      end
    end
  end

  logic take;
  assign take = s1_vld && win_hit;

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_hit    <= 1'b0;
      out_idx    <= '0;
      out_offs_x <= '0;
      out_offs_y <= '0;
    end else begin
      out_valid  <= s1_vld;
      out_hit    <= take;
      out_idx    <= take ? win_idx : 3'd0;
      out_offs_x <= take ? win_ox  : '0;
      out_offs_y <= take ? win_oy  : '0;
    end
  end

endmodule
